atomic_reader: RTL and testbench
================================

ATOMIC_READER -- requirements
Module: atomic_reader

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports listed as: name  direction  width  meaning.
REQ-002 clk  input  1  single clock, all flops rising-edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 rd_start_i  input  1  pulse/level request to perform one 64-bit atomic read.
REQ-005 busy_o  output  1  high while a read sequence is in progress or a result is pending.
REQ-006 req_o  output  1  read request to the counter.
REQ-007 atomic_o  output  1  marks req_o as the first (low-word) access.
REQ-008 ack_i  input  1  counter acknowledge, due exactly one cycle after each req_o cycle.
REQ-009 count_i  input  32  counter data, valid when ack_i=1.
REQ-010 data_o  output  64  assembled counter value {high, low}.
REQ-011 valid_o  output  1  data_o valid; held until accepted.
REQ-012 ready_i  input  1  consumer accepts data_o when valid_o&ready_i.
REQ-013 err_o  output  1  sticky: expected ack_i missing or unexpected ack_i.
REQ-014 nonmono_o  output  1  sticky: accepted 64-bit value lower than previous accepted value.
REQ-015 rd_cnt_o  output  16  number of completed (accepted) reads, wraps 0xFFFF->0x0000.

Function
REQ-016 FSM states SHALL be IDLE, REQ_LO, REQ_HI, WAIT_HI, DONE; req_o/atomic_o/valid_o/busy_o decoded from the state register only.
REQ-017 IDLE: req_o=0, atomic_o=0; rd_start_i=1 -> REQ_LO; else stay.
REQ-018 REQ_LO: req_o=1, atomic_o=1 for exactly one cycle; -> REQ_HI unconditionally.
REQ-019 REQ_HI: req_o=1, atomic_o=0 for exactly one cycle; ack_i=1 captures count_i into low word; ack_i=0 sets err_o and -> IDLE; else -> WAIT_HI.
REQ-020 WAIT_HI: req_o=0; ack_i=1 captures count_i into high word and -> DONE; ack_i=0 sets err_o and -> IDLE.
REQ-021 DONE: valid_o=1, data_o stable; on ready_i=1 -> IDLE, or -> REQ_LO if rd_start_i=1 in the same cycle.
REQ-022 Latency SHALL be 4 cycles from rd_start_i sampled high in IDLE to valid_o=1; back-to-back reads SHALL complete every 4 cycles with ready_i held high.
REQ-023 rd_start_i SHALL be ignored in REQ_LO, REQ_HI, WAIT_HI, and in DONE when ready_i=0 (no queuing).
REQ-024 ack_i=1 in IDLE, REQ_LO or DONE SHALL set err_o and not change state or data_o.
REQ-025 busy_o SHALL be 1 in every state except IDLE.
REQ-026 On each accept (valid_o&ready_i): rd_cnt_o increments by 1 (mod 2^16); data_o compared unsigned 64-bit against last accepted value; if less, nonmono_o set; last accepted value updated.
REQ-027 Comparison SHALL be skipped for the first accept after reset.
REQ-028 data_o SHALL hold its last value outside DONE; the low word register SHALL not be overwritten by the high-word capture.
REQ-029 err_o and nonmono_o SHALL clear only by reset.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state=IDLE, req_o=0, atomic_o=0, valid_o=0, busy_o=0, err_o=0, nonmono_o=0, rd_cnt_o=0, data_o=0, last-value register=0, first-accept flag set.
REQ-031 Reset asserted mid-sequence SHALL abort the read with no partial data_o and no rd_cnt_o change; after release, rd_start_i is honoured from the first rising edge with reset_n=1.

Verification
REQ-032 Single read: counter model preloaded 0x0000_0001_FFFF_FFFE, rd_start_i pulse at T0 -> req_o T1-T2, atomic_o T1 only, valid_o T4, data_o=0x0000_0001_FFFF_FFFE, rd_cnt_o=1.
REQ-033 Carry across read: counter at 0x0000_0000_FFFF_FFFF, trig between low and high access -> data_o=0x0000_0000_FFFF_FFFF (model latches high word on atomic access), nonmono_o=0.
REQ-034 Back-to-back: rd_start_i and ready_i held high 12 cycles -> 3 reads, valid_o at T4, T8, T12, rd_cnt_o=3, req_o pattern 1,1,0,0 repeating.
REQ-035 Backpressure: ready_i=0 for 5 cycles in DONE -> valid_o and data_o stable, req_o=0, rd_start_i ignored; ready_i=1 -> IDLE, rd_cnt_o+1.
REQ-036 Missing ack: model drops ack in WAIT_HI -> err_o=1, state IDLE, valid_o never asserts, rd_cnt_o unchanged.
REQ-037 Reset mid-read: reset_n low during REQ_HI -> all outputs 0 immediately; new rd_start_i after release completes normally with rd_cnt_o=1.

Source files
------------

// File: rtl/atomic_reader.sv
// atomic_reader: reads a 64-bit free-running counter through a 32-bit port
// as one atomic pair of accesses. It then presents the assembled value with a
// valid/ready handshake and checks consecutive accepted values for monotonicity.
//
// Ports:
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   rd_start_i   request one 64-bit read (pulse or level)
//   busy_o       high in every state except IDLE
//   req_o        read request to the counter (two consecutive cycles per read)
//   atomic_o     marks the first (low-word) request of a pair
//   ack_i        counter acknowledge, one cycle after each req_o cycle
//   count_i      counter data, valid with ack_i
//   data_o       assembled {high, low} value, stable outside DONE
//   valid_o      data_o valid, held until accepted
//   ready_i      consumer accepts data_o when valid_o & ready_i
//   err_o        sticky: missing or unexpected ack_i
//   nonmono_o    sticky: accepted value lower than the previous accepted value
//   rd_cnt_o     number of accepted reads, wraps modulo 2^16
module atomic_reader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd_start_i,
  output logic        busy_o,
  output logic        req_o,
  output logic        atomic_o,
  input  logic        ack_i,
  input  logic [31:0] count_i,
  output logic [63:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        err_o,
  output logic        nonmono_o,
  output logic [15:0] rd_cnt_o
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned DATA_W = 2 * WORD_W;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_LO  = 3'd1,
    S_REQ_HI  = 3'd2,
    S_WAIT_HI = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [WORD_W-1:0]   lo_q;
  logic [DATA_W-1:0]   last_q;
  logic                first_q;

  logic                lo_cap_c;
  logic                hi_cap_c;
  logic                ack_err_c;
  logic                accept_c;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a missing ack in either word phase abandons the read
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rd_start_i) state_d = S_REQ_LO;
      end
      S_REQ_LO: begin
        state_d = S_REQ_HI;
      end
      S_REQ_HI: begin
        state_d = ack_i ? S_WAIT_HI : S_IDLE;
      end
      S_WAIT_HI: begin
        state_d = ack_i ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (ready_i) state_d = rd_start_i ? S_REQ_LO : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and strobe decode from the state register
  always_comb begin
    req_o     = 1'b0;
    atomic_o  = 1'b0;
    valid_o   = 1'b0;
    busy_o    = 1'b1;
    lo_cap_c  = 1'b0;
    hi_cap_c  = 1'b0;
    ack_err_c = 1'b0;
    accept_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o    = 1'b0;
        ack_err_c = ack_i;
      end
      S_REQ_LO: begin
        req_o     = 1'b1;
        atomic_o  = 1'b1;
        ack_err_c = ack_i;
      end
      S_REQ_HI: begin
        // The ack seen here answers the atomic low-word request
        req_o     = 1'b1;
        lo_cap_c  = ack_i;
        ack_err_c = !ack_i;
      end
      S_WAIT_HI: begin
        hi_cap_c  = ack_i;
        ack_err_c = !ack_i;
      end
      S_DONE: begin
        valid_o   = 1'b1;
        ack_err_c = ack_i;
        accept_c  = ready_i;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // Low word is parked separately so data_o only changes once both halves exist
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_q <= '0;
    end else if (lo_cap_c) begin
      lo_q <= count_i;
    end
  end

  // Result register, loaded with the full pair on the high-word ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_o <= '0;
    end else if (hi_cap_c) begin
      data_o <= {count_i, lo_q};
    end
  end

  // Sticky protocol error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_o <= 1'b0;
    end else if (ack_err_c) begin
      err_o <= 1'b1;
    end
  end

  // Accept bookkeeping: read counter, last accepted value, monotonicity check
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_o  <= '0;
      last_q    <= '0;
      first_q   <= 1'b1;
      nonmono_o <= 1'b0;
    end else if (accept_c) begin
      rd_cnt_o <= rd_cnt_o + CNT_W'(1);
      last_q   <= data_o;
      first_q  <= 1'b0;
      // No predecessor exists for the first accepted value after reset
      if (!first_q && (data_o < last_q)) begin
        nonmono_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_atomic_reader.sv
// Testbench for atomic_reader: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the read sequence
// and a bench-side 64-bit counter that snapshots on the atomic access.
module tb_atomic_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_start_i;
  logic        busy_o;
  logic        req_o;
  logic        atomic_o;
  logic        ack_i;
  logic [31:0] count_i;
  logic [63:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        err_o;
  logic        nonmono_o;
  logic [15:0] rd_cnt_o;

  atomic_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_start_i (rd_start_i),
    .busy_o     (busy_o),
    .req_o      (req_o),
    .atomic_o   (atomic_o),
    .ack_i      (ack_i),
    .count_i    (count_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .err_o      (err_o),
    .nonmono_o  (nonmono_o),
    .rd_cnt_o   (rd_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: age = cycles since the start was taken (-1 when no read in flight)
  int          age;
  logic [63:0] ctr;
  logic [63:0] ctr_step;
  logic [63:0] snap;
  logic [63:0] m_data;
  logic [63:0] m_last;
  logic [15:0] m_cnt;
  bit          m_err;
  bit          m_nonmono;
  bit          m_first;

  // Expected outputs for the current cycle
  bit          e_busy, e_req, e_atomic, e_valid, e_err, e_nonmono;
  logic [63:0] e_data;
  logic [15:0] e_cnt;

  int          nv;
  logic [11:0] rq;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endfunction

  function automatic void model_reset();
    age       = -1;
    m_data    = '0;
    m_last    = '0;
    m_cnt     = '0;
    m_err     = 1'b0;
    m_nonmono = 1'b0;
    m_first   = 1'b1;
  endfunction

  function automatic void publish();
    e_busy    = (age >= 1);
    e_req     = (age == 1) || (age == 2);
    e_atomic  = (age == 1);
    e_valid   = (age >= 4);
    e_err     = m_err;
    e_nonmono = m_nonmono;
    e_data    = m_data;
    e_cnt     = m_cnt;
  endfunction

  // Single compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_o",    64'(busy_o),    64'(e_busy));
      chk("req_o",     64'(req_o),     64'(e_req));
      chk("atomic_o",  64'(atomic_o),  64'(e_atomic));
      chk("valid_o",   64'(valid_o),   64'(e_valid));
      chk("err_o",     64'(err_o),     64'(e_err));
      chk("nonmono_o", 64'(nonmono_o), 64'(e_nonmono));
      chk("data_o",    data_o,         e_data);
      chk("rd_cnt_o",  64'(rd_cnt_o),  64'(e_cnt));
    end
  end

  // One clock cycle: drive inputs, advance the model, wait for the edge
  task automatic run(input bit start, input bit rdy, input bit drop,
                     input bit spur, input bit rstn);
    bit          sched;
    bit          ack;
    logic [31:0] cnt;
    // Acks are due the cycle after each of the two requests
    sched = (age == 2) || (age == 3);
    ack   = rstn && (sched ? !drop : spur);
    if (age == 1) snap = ctr;
    if (age == 2)      cnt = snap[31:0];
    else if (age == 3) cnt = snap[63:32];
    else               cnt = $urandom;
    rd_start_i = start;
    ready_i    = rdy;
    ack_i      = ack;
    count_i    = cnt;
    reset_n    = rstn;
    if (!rstn) begin
      model_reset();
      publish();
      #1;
      chk("rst_now_req",   64'(req_o),   64'd0);
      chk("rst_now_busy",  64'(busy_o),  64'd0);
      chk("rst_now_valid", 64'(valid_o), 64'd0);
      chk("rst_now_data",  data_o,       64'd0);
    end else if (age < 0) begin
      if (ack) m_err = 1'b1;
      if (start) age = 1;
    end else if (age == 1) begin
      if (ack) m_err = 1'b1;
      age = 2;
    end else if (age == 2) begin
      if (!ack) begin m_err = 1'b1; age = -1; end
      else age = 3;
    end else if (age == 3) begin
      if (!ack) begin m_err = 1'b1; age = -1; end
      else begin m_data = snap; age = 4; end
    end else begin
      if (ack) m_err = 1'b1;
      if (rdy) begin
        m_cnt = m_cnt + 16'd1;
        if (!m_first && (m_data < m_last)) m_nonmono = 1'b1;
        m_last  = m_data;
        m_first = 1'b0;
        age = start ? 1 : -1;
      end else begin
        age = age + 1;
      end
    end
    ctr = ctr + ctr_step;
    @(posedge clk);
    #1;
    publish();
  endtask

  task automatic do_reset();
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n    = 1'b1;
    rd_start_i = 1'b0;
    ready_i    = 1'b0;
    ack_i      = 1'b0;
    count_i    = '0;
    ctr        = '0;
    ctr_step   = '0;
    snap       = '0;
    nv         = 0;
    rq         = '0;
    model_reset();
    publish();
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_cnt",  64'(rd_cnt_o), 64'd0);
    chk("reset_data", data_o,        64'd0);
    chk("reset_busy", 64'(busy_o),   64'd0);
    do_reset();

    // Single read with a fixed counter value
    ctr = 64'h0000_0001_FFFF_FFFE;
    ctr_step = 64'd0;
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("single_t1_req",    64'(req_o),    64'd1);
    chk("single_t1_atomic", 64'(atomic_o), 64'd1);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("single_t2_req",    64'(req_o),    64'd1);
    chk("single_t2_atomic", 64'(atomic_o), 64'd0);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("single_t3_valid",  64'(valid_o),  64'd0);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("single_t4_valid",  64'(valid_o),  64'd1);
    chk("single_t4_data",   data_o,        64'h0000_0001_FFFF_FFFE);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("single_cnt",       64'(rd_cnt_o), 64'd1);
    chk("single_idle",      64'(busy_o),   64'd0);

    // Counter carries from low to high word while the read is in flight
    do_reset();
    ctr = 64'h0000_0000_FFFF_FFFE;
    ctr_step = 64'd1;
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("carry_data",    data_o,         64'h0000_0000_FFFF_FFFF);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("carry_nonmono", 64'(nonmono_o), 64'd0);
    chk("carry_cnt",     64'(rd_cnt_o),  64'd1);

    // Back-to-back reads with start and ready held high for 12 cycles
    do_reset();
    nv = 0;
    rq = '0;
    for (int i = 0; i < 13; i++) begin
      run(i < 12, 1'b1, 1'b0, 1'b0, 1'b1);
      if (i < 12) rq[11-i] = req_o;
      if (valid_o) nv++;
    end
    chk("b2b_valids",  64'(nv),       64'd3);
    chk("b2b_req_pat", 64'(rq),       64'hCCC);
    chk("b2b_cnt",     64'(rd_cnt_o), 64'd3);

    // Backpressure in DONE with start asserted and ignored
    do_reset();
    ctr = 64'h1234_5678_9ABC_DEF0;
    ctr_step = 64'd0;
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("bp_valid", 64'(valid_o), 64'd1);
      chk("bp_data",  data_o,       64'h1234_5678_9ABC_DEF0);
      chk("bp_req",   64'(req_o),   64'd0);
    end
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("bp_cnt",  64'(rd_cnt_o), 64'd1);
    chk("bp_idle", 64'(busy_o),   64'd0);

    // High-word ack dropped
    do_reset();
    ctr = 64'hA5A5_5A5A_0F0F_F0F0;
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("miss_err",  64'(err_o),  64'd1);
    chk("miss_idle", 64'(busy_o), 64'd0);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      run(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      if (valid_o) nv++;
    end
    chk("miss_no_valid", 64'(nv),       64'd0);
    chk("miss_cnt",      64'(rd_cnt_o), 64'd0);

    // Reset asserted during the high-word request
    do_reset();
    ctr = 64'h0000_0000_0000_0042;
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_in_reqhi", 64'(req_o), 64'd1);
    do_reset();
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_restart", 64'(atomic_o), 64'd1);
    for (int i = 0; i < 3; i++) run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_data", data_o, 64'h0000_0000_0000_0042);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("midrst_cnt",  64'(rd_cnt_o), 64'd1);

    // Randomized traffic, counter reloads, dropped/spurious acks, resets
    do_reset();
    ctr = {32'($urandom), 32'($urandom)};
    for (int i = 0; i < 4000; i++) begin
      ctr_step = 64'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) ctr = {32'($urandom), 32'($urandom)};
      run($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0,
          $urandom_range(0, 149) != 0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
